// File: rtl/vx_dma_requester.sv
// ---------------------------------------------------------------------------
// vx_dma_requester
//
// Purpose:
//   Accepts DMA commands from warps and tags each non-empty command.
//   It issues the command as a registered request, and retires tags when
//   responses return. It keeps a count of outstanding transfers per warp so
//   that a warp can fence on its own DMA traffic.
//
// Ports:
//   i_clk              clock, all state on rising edge
//   i_reset            asynchronous reset, active LOW
//   i_cmd_*            warp command channel (valid/ready, wid, addresses,
//                      byte count, direction 0=G2L 1=L2G)
//   o_req_*/i_req_ready  outgoing DMA request channel (registered);
//                        o_req_tag is the tag zero-extended to 8 bits
//   i_rsp_valid/i_rsp_tag/o_rsp_ready  DMA completion channel
//   i_fence_valid/i_fence_wid/o_fence_ready  per-warp drain query
//   o_busy             any tag in use or a request pending
//   o_err_spurious     one-cycle pulse after a response with a bad tag
// ---------------------------------------------------------------------------
module vx_dma_requester #(
  parameter string INSTANCE_ID = "",
  parameter int    NUM_WARPS   = 4,
  parameter int    NUM_TAGS    = 8,
  localparam int   WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int   TAG_W = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1,
  localparam int   CNT_W = TAG_W + 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [WID_W-1:0] i_cmd_wid,
  input  logic [31:0]      i_cmd_src_addr,
  input  logic [31:0]      i_cmd_dst_addr,
  input  logic [15:0]      i_cmd_size,
  input  logic             i_cmd_direction,
  output logic             o_req_valid,
  output logic [31:0]      o_req_src_addr,
  output logic [31:0]      o_req_dst_addr,
  output logic [15:0]      o_req_size,
  output logic             o_req_direction,
  output logic [7:0]       o_req_tag,
  input  logic             i_req_ready,
  input  logic             i_rsp_valid,
  input  logic [7:0]       i_rsp_tag,
  output logic             o_rsp_ready,
  input  logic             i_fence_valid,
  input  logic [WID_W-1:0] i_fence_wid,
  output logic             o_fence_ready,
  output logic             o_busy,
  output logic             o_err_spurious
);

  logic [NUM_TAGS-1:0] r_inUse;
  logic [WID_W-1:0]    r_tagWid      [NUM_TAGS];
  logic [CNT_W-1:0]    r_outstanding [NUM_WARPS];

  logic        r_reqValid;
  logic [31:0] r_reqSrc;
  logic [31:0] r_reqDst;
  logic [15:0] r_reqSize;
  logic        r_reqDir;
  logic [7:0]  r_reqTag;
  logic        r_errSpurious;

  logic             w_freeFound;
  logic [TAG_W-1:0] w_freeIdx;
  logic             w_accept;
  logic             w_rspInRange;
  logic [TAG_W-1:0] w_rspIdx;
  logic             w_rspHit;
  logic [WID_W-1:0] w_rspWid;

  // Lowest-index free tag. The pool is read from registered state, so a tag
  // released this cycle only becomes allocatable next cycle.
  always_comb begin
    w_freeFound = 1'b0;
    w_freeIdx   = '0;
    for (int t = NUM_TAGS - 1; t >= 0; t--) begin
      if (!r_inUse[t]) begin
        w_freeFound = 1'b1;
        w_freeIdx   = TAG_W'(t);
      end
    end
  end

  assign o_cmd_ready = w_freeFound && (!r_reqValid || i_req_ready);

  // Zero-byte commands handshake normally but never consume a tag.
  assign w_accept = i_cmd_valid && o_cmd_ready && (i_cmd_size != 16'd0);

  assign w_rspInRange = ({1'b0, i_rsp_tag} < 9'(NUM_TAGS));
  assign w_rspIdx     = i_rsp_tag[TAG_W-1:0];
  assign w_rspHit     = i_rsp_valid && w_rspInRange && r_inUse[w_rspIdx];
  assign w_rspWid     = r_tagWid[w_rspIdx];

  // Tag pool and per-warp counters. Allocation and retirement never touch
  // the same tag (one needs it free, the other in use). When both hit the
  // same warp, the counter holds.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_inUse <= '0;
      for (int t = 0; t < NUM_TAGS; t++) r_tagWid[t] <= '0;
      for (int w = 0; w < NUM_WARPS; w++) r_outstanding[w] <= '0;
    end else begin
      for (int t = 0; t < NUM_TAGS; t++) begin
        if (w_accept && (w_freeIdx == TAG_W'(t))) begin
          r_inUse[t]  <= 1'b1;
          r_tagWid[t] <= i_cmd_wid;
        end else if (w_rspHit && (w_rspIdx == TAG_W'(t))) begin
          r_inUse[t] <= 1'b0;
        end
      end
      for (int w = 0; w < NUM_WARPS; w++) begin
        if ((w_accept && (i_cmd_wid == WID_W'(w))) && !(w_rspHit && (w_rspWid == WID_W'(w))))
          r_outstanding[w] <= r_outstanding[w] + CNT_W'(1);
        else if (!(w_accept && (i_cmd_wid == WID_W'(w))) && (w_rspHit && (w_rspWid == WID_W'(w))))
          r_outstanding[w] <= r_outstanding[w] - CNT_W'(1);
      end
    end
  end

  // Request output register. It holds while stalled. It reloads on every
  // accept, so back-to-back issue runs at one request per cycle.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_reqValid <= 1'b0;
      r_reqSrc   <= '0;
      r_reqDst   <= '0;
      r_reqSize  <= '0;
      r_reqDir   <= 1'b0;
      r_reqTag   <= '0;
    end else if (w_accept) begin
      r_reqValid <= 1'b1;
      r_reqSrc   <= i_cmd_src_addr;
      r_reqDst   <= i_cmd_dst_addr;
      r_reqSize  <= i_cmd_size;
      r_reqDir   <= i_cmd_direction;
      r_reqTag   <= 8'(w_freeIdx);
    end else if (i_req_ready) begin
      r_reqValid <= 1'b0;
    end
  end

  // A response that names an unallocated or out-of-range tag is flagged one
  // cycle later and otherwise ignored.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_errSpurious <= 1'b0;
    else          r_errSpurious <= i_rsp_valid && !w_rspHit;
  end

  assign o_req_valid     = r_reqValid;
  assign o_req_src_addr  = r_reqSrc;
  assign o_req_dst_addr  = r_reqDst;
  assign o_req_size      = r_reqSize;
  assign o_req_direction = r_reqDir;
  assign o_req_tag       = r_reqTag;
  assign o_rsp_ready     = 1'b1;
  assign o_fence_ready   = i_fence_valid && (r_outstanding[i_fence_wid] == '0);
  assign o_busy          = (|r_inUse) || r_reqValid;
  assign o_err_spurious  = r_errSpurious;

endmodule

// File: tb/tb_vx_dma_requester.sv
// Directed bench for vx_dma_requester with the default parameters
// (4 warps, 8 tags). Inputs change 1ns after each rising edge, and
// outputs are checked 1ns later.
module tb_vx_dma_requester;

   logic        clk = 1'b0;
   logic        rstN;
   logic        cmdValid;
   logic        cmdReady;
   logic [1:0]  cmdWid;
   logic [31:0] cmdSrc;
   logic [31:0] cmdDst;
   logic [15:0] cmdSize;
   logic        cmdDir;
   logic        reqValid;
   logic [31:0] reqSrc;
   logic [31:0] reqDst;
   logic [15:0] reqSize;
   logic        reqDir;
   logic [7:0]  reqTag;
   logic        reqReady;
   logic        rspValid;
   logic [7:0]  rspTag;
   logic        rspReady;
   logic        fenceValid;
   logic [1:0]  fenceWid;
   logic        fenceReady;
   logic        busy;
   logic        errSpurious;

   int compared   = 0;
   int mismatched = 0;

   // 100 MHz free-running clock.
   always #5 clk = ~clk;

   vx_dma_requester dut (
      .i_clk(clk), .i_reset(rstN),
      .i_cmd_valid(cmdValid), .o_cmd_ready(cmdReady), .i_cmd_wid(cmdWid),
      .i_cmd_src_addr(cmdSrc), .i_cmd_dst_addr(cmdDst), .i_cmd_size(cmdSize),
      .i_cmd_direction(cmdDir),
      .o_req_valid(reqValid), .o_req_src_addr(reqSrc), .o_req_dst_addr(reqDst),
      .o_req_size(reqSize), .o_req_direction(reqDir), .o_req_tag(reqTag),
      .i_req_ready(reqReady),
      .i_rsp_valid(rspValid), .i_rsp_tag(rspTag), .o_rsp_ready(rspReady),
      .i_fence_valid(fenceValid), .i_fence_wid(fenceWid), .o_fence_ready(fenceReady),
      .o_busy(busy), .o_err_spurious(errSpurious)
   );

   // Single comparison point: counts every check and reports any difference.
   task automatic checkOutput(input string name, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
      end
   endtask

   // Drives the command channel and lets combinational outputs settle.
   task automatic applyStimulus(input logic valid, input logic [1:0] wid,
                                input logic [31:0] src, input logic [31:0] dst,
                                input logic [15:0] size, input logic dir);
      cmdValid = valid;
      cmdWid   = wid;
      cmdSrc   = src;
      cmdDst   = dst;
      cmdSize  = size;
      cmdDir   = dir;
      #1;
   endtask

   // Advances to 1ns after the next rising edge.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Queries the fence for one warp.
   task automatic checkFence(input string name, input logic [1:0] wid, input logic expected);
      fenceValid = 1'b1;
      fenceWid   = wid;
      #1;
      checkOutput(name, 32'(fenceReady), 32'(expected));
   endtask

   initial begin
      rstN = 1'b0; reqReady = 1'b1; rspValid = 1'b0; rspTag = '0;
      fenceValid = 1'b0; fenceWid = '0;
      applyStimulus(1'b0, 2'd0, 32'd0, 32'd0, 16'd0, 1'b0);

      // Reset state.
      checkOutput("rst_req_valid", 32'(reqValid), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_cmd_ready", 32'(cmdReady), 32'd1);
      checkOutput("rst_rsp_ready", 32'(rspReady), 32'd1);
      checkOutput("rst_err", 32'(errSpurious), 32'd0);
      cycle();
      cycle();
      rstN = 1'b1;
      #1;

      // Single command, warp 1, 64 bytes.
      applyStimulus(1'b1, 2'd1, 32'h1000, 32'h2000, 16'd64, 1'b0);
      checkOutput("single_cmd_ready", 32'(cmdReady), 32'd1);
      cycle();
      applyStimulus(1'b0, 2'd0, 32'd0, 32'd0, 16'd0, 1'b0);
      checkOutput("single_req_valid", 32'(reqValid), 32'd1);
      checkOutput("single_tag", 32'(reqTag), 32'd0);
      checkOutput("single_src", reqSrc, 32'h1000);
      checkOutput("single_dst", reqDst, 32'h2000);
      checkOutput("single_size", 32'(reqSize), 32'd64);
      checkFence("single_fence_busy", 2'd1, 1'b0);
      cycle();
      checkOutput("single_req_drop", 32'(reqValid), 32'd0);
      checkOutput("single_busy_inflight", 32'(busy), 32'd1);
      rspValid = 1'b1; rspTag = 8'd0;
      #1;
      checkFence("single_fence_rsp_cycle", 2'd1, 1'b0);
      cycle();
      rspValid = 1'b0;
      checkFence("single_fence_after", 2'd1, 1'b1);
      checkOutput("single_busy_idle", 32'(busy), 32'd0);
      checkOutput("single_no_err", 32'(errSpurious), 32'd0);

      // Nine commands, warp 2: tags 0..7, then pool exhausted.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 2'd2, 32'(i), 32'h100 + 32'(i), 16'd16, 1'b1);
         checkOutput($sformatf("fill_ready_%0d", i), 32'(cmdReady), 32'd1);
         cycle();
         checkOutput($sformatf("fill_valid_%0d", i), 32'(reqValid), 32'd1);
         checkOutput($sformatf("fill_tag_%0d", i), 32'(reqTag), 32'(i));
      end
      applyStimulus(1'b1, 2'd2, 32'd8, 32'h108, 16'd16, 1'b1);
      checkOutput("full_cmd_ready", 32'(cmdReady), 32'd0);
      cycle();
      checkOutput("full_req_valid", 32'(reqValid), 32'd0);
      rspValid = 1'b1; rspTag = 8'd3;
      #1;
      checkOutput("free_same_cycle_ready", 32'(cmdReady), 32'd0);
      cycle();
      rspValid = 1'b0;
      #1;
      checkOutput("free_next_cycle_ready", 32'(cmdReady), 32'd1);
      cycle();
      applyStimulus(1'b0, 2'd0, 32'd0, 32'd0, 16'd0, 1'b0);
      checkOutput("ninth_valid", 32'(reqValid), 32'd1);
      checkOutput("ninth_tag", 32'(reqTag), 32'd3);
      checkOutput("ninth_src", reqSrc, 32'd8);
      checkFence("fill_fence_w2", 2'd2, 1'b0);
      for (int t = 0; t < 8; t++) begin
         rspValid = 1'b1; rspTag = 8'(t);
         cycle();
      end
      rspValid = 1'b0;
      checkFence("drain_fence_w2", 2'd2, 1'b1);
      checkOutput("drain_busy", 32'(busy), 32'd0);

      // Stall: request must hold for five cycles, cmd_ready low.
      reqReady = 1'b0;
      applyStimulus(1'b1, 2'd0, 32'hA0A0, 32'hB0B0, 16'd100, 1'b1);
      cycle();
      applyStimulus(1'b1, 2'd3, 32'hDEAD, 32'hBEEF, 16'd7, 1'b0);
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("stall_valid_%0d", i), 32'(reqValid), 32'd1);
         checkOutput($sformatf("stall_src_%0d", i), reqSrc, 32'hA0A0);
         checkOutput($sformatf("stall_dst_%0d", i), reqDst, 32'hB0B0);
         checkOutput($sformatf("stall_size_%0d", i), 32'(reqSize), 32'd100);
         checkOutput($sformatf("stall_dir_%0d", i), 32'(reqDir), 32'd1);
         checkOutput($sformatf("stall_tag_%0d", i), 32'(reqTag), 32'd0);
         checkOutput($sformatf("stall_cmd_ready_%0d", i), 32'(cmdReady), 32'd0);
         cycle();
      end
      applyStimulus(1'b0, 2'd0, 32'd0, 32'd0, 16'd0, 1'b0);
      reqReady = 1'b1;
      cycle();
      checkOutput("stall_release", 32'(reqValid), 32'd0);

      // Spurious responses: free tag 5, out-of-range tag 200.
      checkFence("spur_fence_before", 2'd0, 1'b0);
      rspValid = 1'b1; rspTag = 8'd5;
      #1;
      checkOutput("spur_err_same_cycle", 32'(errSpurious), 32'd0);
      cycle();
      rspValid = 1'b0;
      #1;
      checkOutput("spur_err_pulse", 32'(errSpurious), 32'd1);
      checkFence("spur_fence_unchanged", 2'd0, 1'b0);
      checkOutput("spur_busy", 32'(busy), 32'd1);
      cycle();
      checkOutput("spur_err_clear", 32'(errSpurious), 32'd0);
      rspValid = 1'b1; rspTag = 8'd200;
      cycle();
      rspValid = 1'b0;
      #1;
      checkOutput("range_err_pulse", 32'(errSpurious), 32'd1);
      cycle();
      checkOutput("range_err_clear", 32'(errSpurious), 32'd0);
      rspValid = 1'b1; rspTag = 8'd0;
      cycle();
      rspValid = 1'b0;
      checkFence("spur_fence_drained", 2'd0, 1'b1);

      // Zero-size command: accepted, nothing issued.
      applyStimulus(1'b1, 2'd3, 32'h5, 32'h6, 16'd0, 1'b0);
      checkOutput("zero_cmd_ready", 32'(cmdReady), 32'd1);
      cycle();
      applyStimulus(1'b0, 2'd0, 32'd0, 32'd0, 16'd0, 1'b0);
      checkOutput("zero_no_req", 32'(reqValid), 32'd0);
      checkOutput("zero_busy", 32'(busy), 32'd0);
      checkFence("zero_fence", 2'd3, 1'b1);

      // Accept and retire for the same warp in one cycle.
      applyStimulus(1'b1, 2'd1, 32'h10, 32'h20, 16'd8, 1'b0);
      cycle();
      rspValid = 1'b1; rspTag = 8'd0;
      applyStimulus(1'b1, 2'd1, 32'h11, 32'h21, 16'd8, 1'b0);
      cycle();
      rspValid = 1'b0;
      applyStimulus(1'b0, 2'd0, 32'd0, 32'd0, 16'd0, 1'b0);
      checkOutput("simul_tag", 32'(reqTag), 32'd1);
      checkFence("simul_fence_held", 2'd1, 1'b0);
      rspValid = 1'b1; rspTag = 8'd1;
      cycle();
      rspValid = 1'b0;
      checkFence("simul_fence_drained", 2'd1, 1'b1);

      // Reset mid-transfer: three tags in flight plus one stalled request.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 2'(i), 32'h300 + 32'(i), 32'h400, 16'd32, 1'b0);
         cycle();
      end
      reqReady = 1'b0;
      applyStimulus(1'b1, 2'd3, 32'h333, 32'h444, 16'd32, 1'b0);
      cycle();
      applyStimulus(1'b0, 2'd0, 32'd0, 32'd0, 16'd0, 1'b0);
      checkOutput("pre_reset_busy", 32'(busy), 32'd1);
      rstN = 1'b0;
      #1;
      checkOutput("mid_reset_req_valid", 32'(reqValid), 32'd0);
      checkOutput("mid_reset_busy", 32'(busy), 32'd0);
      checkOutput("mid_reset_cmd_ready", 32'(cmdReady), 32'd1);
      cycle();
      rstN = 1'b1;
      reqReady = 1'b1;
      cycle();
      checkOutput("post_reset_busy", 32'(busy), 32'd0);
      checkOutput("post_reset_req_valid", 32'(reqValid), 32'd0);
      for (int w = 0; w < 4; w++)
         checkFence($sformatf("post_reset_fence_w%0d", w), 2'(w), 1'b1);
      rspValid = 1'b1; rspTag = 8'd1;
      cycle();
      rspValid = 1'b0;
      #1;
      checkOutput("post_reset_spurious", 32'(errSpurious), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
